core_mem_bridge: RTL and testbench

Data-memory slave on the CPU core's load/store port: it accepts single-word read (lw/flw) and write (sw/fsw) requests on the core's AR/R/AW/W/B signals and services them from an internal word-addressed block RAM. It sits directly downstream of the core. It produces the one-cycle `core_RVALID`/`core_BVALID` pulses that release the core's PC stall. The core holds the request valid level-high for as long as the memory instruction is current, so this block must turn that level into exactly one transaction.

---
 rtl/core_mem_bridge.sv | 144 ++++++++++++++
 tb/tb_core_mem_bridge.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_mem_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : core_mem_bridge                                            |
// | Description : Data-memory slave on the core load/store port. It turns   |
// |               level-held AR/AW valids into single transactions served    |
// |               from an internal word-addressed block RAM, and returns     |
// |               one-cycle RVALID/BVALID pulses.                            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module core_mem_bridge #(
  parameter int ADDR_WIDTH   = 15,
  parameter int READ_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] core_ARADDR,
  input  logic        core_ARVALID,
  output logic [31:0] core_RDATA,
  output logic        core_RVALID,
  input  logic [31:0] core_AWADDR,
  input  logic        core_AWVALID,
  input  logic [31:0] core_WDATA,
  output logic        core_BVALID,
  output logic        busy,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RD_RESP = 2'd2,
    WR_RESP = 2'd3
  } state_t;

  localparam int         DEPTH  = 2 ** ADDR_WIDTH;
  localparam logic [3:0] LAT_M1 = 4'(READ_LATENCY - 1);

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   ridx_q, ridx_d;
  logic                    roor_q, roor_d;
  logic [31:0]             rdata_q, rdata_d;
  logic                    err_q, err_d;
  logic                    rvalid_q, bvalid_q, busy_q;
  logic [31:0]             mem_q [DEPTH];

  // Address decode of both request channels
  logic [ADDR_WIDTH-1:0]   ar_idx, aw_idx, rd_idx;
  logic                    ar_oor, aw_oor, ar_mis, aw_mis, rd_oor;
  logic                    mem_we;

  assign ar_idx = core_ARADDR[ADDR_WIDTH+1:2];
  assign aw_idx = core_AWADDR[ADDR_WIDTH+1:2];
  assign ar_oor = (core_ARADDR >> (ADDR_WIDTH + 2)) != 32'd0;
  assign aw_oor = (core_AWADDR >> (ADDR_WIDTH + 2)) != 32'd0;
  assign ar_mis = core_ARADDR[1:0] != 2'b00;
  assign aw_mis = core_AWADDR[1:0] != 2'b00;

  // Next-state, acceptance and read-data capture; read wins over write in IDLE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ridx_d  = ridx_q;
    roor_d  = roor_q;
    err_d   = err_q;
    rd_idx  = ridx_q;
    rd_oor  = roor_q;
    mem_we  = 1'b0;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (core_ARVALID) begin
          ridx_d  = ar_idx;
          roor_d  = ar_oor;
          rd_idx  = ar_idx;
          rd_oor  = ar_oor;
          err_d   = err_q | ar_oor | ar_mis;
          cnt_d   = LAT_M1;
          state_d = (READ_LATENCY == 1) ? RD_RESP : RD_WAIT;
        end else if (core_AWVALID) begin
          // Out-of-range writes are dropped but still acknowledged
          mem_we  = ~aw_oor & ~rst;
          err_d   = err_q | aw_oor | aw_mis;
          state_d = WR_RESP;
        end
      end
      RD_WAIT: begin
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = RD_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RD_RESP: state_d = IDLE;
      WR_RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // RDATA changes only on entry to the response cycle
    if (state_d == RD_RESP && state_q != RD_RESP) begin
      rdata_d = rd_oor ? 32'd0 : mem_q[rd_idx];
    end
  end

  // Control state and registered outputs, aborted asynchronously by rst
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      ridx_q   <= '0;
      roor_q   <= 1'b0;
      rdata_q  <= 32'd0;
      err_q    <= 1'b0;
      rvalid_q <= 1'b0;
      bvalid_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ridx_q   <= ridx_d;
      roor_q   <= roor_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      rvalid_q <= (state_d == RD_RESP);
      bvalid_q <= (state_d == WR_RESP);
      busy_q   <= (state_d != IDLE);
    end
  end

  // Block RAM write port; contents survive reset
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[aw_idx] <= core_WDATA;
    end
  end

  assign core_RDATA  = rdata_q;
  assign core_RVALID = rvalid_q;
  assign core_BVALID = bvalid_q;
  assign busy        = busy_q;
  assign err         = err_q;

endmodule
`default_nettype wire

// File: tb/tb_core_mem_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_core_mem_bridge                                         |
// | Description : Self-checking bench for core_mem_bridge with a timeline    |
// |               reference model and directed plus random stimulus.         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_core_mem_bridge;

  localparam int AW  = 15;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] core_ARADDR = 32'd0;
  logic        core_ARVALID = 1'b0;
  logic [31:0] core_RDATA;
  logic        core_RVALID;
  logic [31:0] core_AWADDR = 32'd0;
  logic        core_AWVALID = 1'b0;
  logic [31:0] core_WDATA = 32'd0;
  logic        core_BVALID;
  logic        busy;
  logic        err;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  core_mem_bridge #(.ADDR_WIDTH(AW), .READ_LATENCY(LAT)) dut (
    .clk          (clk),
    .rst          (rst),
    .core_ARADDR  (core_ARADDR),
    .core_ARVALID (core_ARVALID),
    .core_RDATA   (core_RDATA),
    .core_RVALID  (core_RVALID),
    .core_AWADDR  (core_AWADDR),
    .core_AWVALID (core_AWVALID),
    .core_WDATA   (core_WDATA),
    .core_BVALID  (core_BVALID),
    .busy         (busy),
    .err          (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b, want %0b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model: one transaction on a cycle timeline ----
  logic [31:0] mmem [int];
  int          rv_cyc  = -1;
  int          bv_cyc  = -1;
  int          busy_lo = 0;
  int          busy_hi = -1;
  int          free_at = 0;
  logic        m_err   = 1'b0;
  logic [31:0] held    = 32'd0;
  logic [31:0] pend    = 32'd0;

  function automatic logic is_oor(input logic [31:0] a);
    return (a >> (AW + 2)) != 32'd0;
  endfunction

  function automatic logic is_mis(input logic [31:0] a);
    return a[1:0] != 2'b00;
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'(a[AW+1:2]);
  endfunction

  function automatic logic [31:0] mread(input int i);
    return mmem.exists(i) ? mmem[i] : 32'd0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rv_cyc  = -1;
      bv_cyc  = -1;
      busy_lo = 0;
      busy_hi = -1;
      free_at = 0;
      m_err   = 1'b0;
      held    = 32'd0;
    end else begin
      if (cyc >= free_at) begin
        if (core_ARVALID) begin
          m_err   = m_err | is_oor(core_ARADDR) | is_mis(core_ARADDR);
          pend    = is_oor(core_ARADDR) ? 32'd0 : mread(widx(core_ARADDR));
          rv_cyc  = cyc + LAT;
          busy_lo = cyc + 1;
          busy_hi = cyc + LAT;
          free_at = cyc + LAT + 1;
        end else if (core_AWVALID) begin
          m_err = m_err | is_oor(core_AWADDR) | is_mis(core_AWADDR);
          if (!is_oor(core_AWADDR)) mmem[widx(core_AWADDR)] = core_WDATA;
          bv_cyc  = cyc + 1;
          busy_lo = cyc + 1;
          busy_hi = cyc + 1;
          free_at = cyc + 2;
        end
      end
      if (rv_cyc == cyc + 1) held = pend;
    end
  end

  // Every cycle: outputs against the model
  always @(negedge clk) begin
    chk1("rvalid", core_RVALID, cyc == rv_cyc);
    chk1("bvalid", core_BVALID, cyc == bv_cyc);
    chk1("busy", busy, (cyc >= busy_lo) && (cyc <= busy_hi));
    chk1("err", err, m_err);
    chk("rdata", core_RDATA, held);
  end

  // ---------------- directed helpers (enter and leave at #1 in an IDLE cycle)
  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    core_AWADDR  = a;
    core_WDATA   = d;
    core_AWVALID = 1'b1;
    @(posedge clk); #1;
    core_AWVALID = 1'b0;
    @(negedge clk);
    chk1("wr_bvalid", core_BVALID, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic do_read(input string name, input logic [31:0] a, input logic [31:0] exp);
    core_ARADDR  = a;
    core_ARVALID = 1'b1;
    @(posedge clk); #1;
    core_ARVALID = 1'b0;
    repeat (LAT - 1) @(posedge clk);
    @(negedge clk);
    chk1({name, "_rvalid"}, core_RVALID, 1'b1);
    chk(name, core_RDATA, exp);
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] gen_addr();
    logic [31:0] a;
    int          sel;
    sel = int'($urandom_range(0, 9));
    a   = 32'h400 + 32'(4 * $urandom_range(0, 15));
    if (sel == 0) a = a | (32'd1 << $urandom_range(AW + 2, 31));
    if (sel == 1) a[1:0] = 2'($urandom_range(1, 3));
    return a;
  endfunction

  initial begin
    int prev;
    logic got;

    // Reset with both valids high
    #1;
    rst          = 1'b1;
    core_ARADDR  = 32'h4;
    core_ARVALID = 1'b1;
    core_AWADDR  = 32'h8;
    core_WDATA   = 32'hA5A5A5A5;
    core_AWVALID = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk1("rst_rvalid", core_RVALID, 1'b0);
      chk1("rst_bvalid", core_BVALID, 1'b0);
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_err", err, 1'b0);
      chk("rst_rdata", core_RDATA, 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    core_ARVALID = 1'b0;
    @(negedge clk);
    chk1("first_read_busy", busy, 1'b1);
    @(posedge clk);
    @(negedge clk);
    chk1("first_read_rvalid", core_RVALID, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    core_AWVALID = 1'b0;
    @(negedge clk);
    chk1("pending_write_bvalid", core_BVALID, 1'b1);
    @(posedge clk); #1;

    // Write then read
    do_write(32'h40, 32'hDEADBEEF);
    do_read("wr_rd_data", 32'h40, 32'hDEADBEEF);
    chk1("wr_rd_err", err, 1'b0);

    // Back-to-back reads with the valid held high
    do_write(32'h0, 32'd1);
    do_write(32'h4, 32'd2);
    do_write(32'h8, 32'd3);
    core_ARADDR  = 32'h0;
    core_ARVALID = 1'b1;
    prev = 0;
    for (int k = 0; k < 3; k++) begin
      got = 1'b0;
      for (int t = 0; t < 10 && !got; t++) begin
        @(negedge clk);
        if (core_RVALID) got = 1'b1;
      end
      chk1("b2b_pulse", got, 1'b1);
      chk("b2b_data", core_RDATA, 32'(k + 1));
      if (k > 0) chk("b2b_spacing", 32'(cyc - prev), 32'(LAT + 1));
      prev = cyc;
      @(posedge clk); #1;
      if (k < 2) core_ARADDR = 32'(4 * (k + 1));
      else core_ARVALID = 1'b0;
    end

    // Simultaneous requests: read first, write afterwards
    do_write(32'h10, 32'h12345678);
    core_ARADDR  = 32'h10;
    core_ARVALID = 1'b1;
    core_AWADDR  = 32'h20;
    core_WDATA   = 32'h55;
    core_AWVALID = 1'b1;
    @(posedge clk); #1;
    core_ARVALID = 1'b0;
    @(negedge clk);
    chk1("sim_no_early_bvalid", core_BVALID, 1'b0);
    repeat (LAT - 1) @(posedge clk);
    @(negedge clk);
    chk1("sim_rvalid", core_RVALID, 1'b1);
    chk("sim_rdata", core_RDATA, 32'h12345678);
    @(posedge clk); #1;
    @(posedge clk); #1;
    core_AWVALID = 1'b0;
    @(negedge clk);
    chk1("sim_bvalid", core_BVALID, 1'b1);
    @(posedge clk); #1;
    do_read("sim_readback", 32'h20, 32'h55);

    // Error cases
    do_read("mis_read", 32'h42, 32'hDEADBEEF);
    chk1("mis_err", err, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk1("err_cleared", err, 1'b0);
    do_write(32'h00020000, 32'h55);
    chk1("oor_wr_err", err, 1'b1);
    do_read("oor_no_alias", 32'h0, 32'd1);
    do_read("oor_read", 32'h00020000, 32'd0);

    // Reset one cycle after read acceptance
    core_ARADDR  = 32'h40;
    core_ARVALID = 1'b1;
    @(posedge clk); #1;
    core_ARVALID = 1'b0;
    #1 rst = 1'b1;
    @(negedge clk);
    chk1("midrst_busy", busy, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk1("midrst_no_rvalid", core_RVALID, 1'b0);
    @(posedge clk); #1;
    do_read("midrst_after", 32'h40, 32'hDEADBEEF);

    // Random traffic over a preloaded pool of words
    for (int i = 0; i < 16; i++) do_write(32'h400 + 32'(4 * i), $urandom);
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      if (rst) rst = 1'b0;
      core_ARVALID = ($urandom_range(0, 2) == 0);
      core_AWVALID = ($urandom_range(0, 2) == 0);
      core_ARADDR  = gen_addr();
      core_AWADDR  = gen_addr();
      core_WDATA   = $urandom;
      if ($urandom_range(0, 49) == 0) begin
        #2 rst = 1'b1;
      end
    end
    @(posedge clk); #1;
    rst          = 1'b0;
    core_ARVALID = 1'b0;
    core_AWVALID = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
